wrap_counter: RTL and testbench

//  Parametrised range counter: counts between START and LIMIT inclusive, up or down, on an enable.
//  Two modes: free-running wrap, or one-shot (stop at the terminal value).

---
 rtl/wrap_counter_if.sv | 16 +
 rtl/wrap_counter.sv | 72 +++++++
 tb/tb_wrap_counter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/wrap_counter_if.sv
// wrap_counter_if: control and status bundle for wrap_counter
interface wrap_counter_if #(
   parameter int WIDTH = 24
);
   logic             en;
   logic             dir;
   logic             oneshot;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             done;
   modport master (output en, dir, oneshot, clear, load, load_val, input count, tc, done);
   modport slave  (input en, dir, oneshot, clear, load, load_val, output count, tc, done);
endinterface

// File: rtl/wrap_counter.sv
// wrap_counter: START..LIMIT up/down range counter, wrap or one-shot; WRAP_COUNTER_PRESCALE_EN adds a step prescaler
module wrap_counter #(
   parameter int               WIDTH    = 24,
   parameter logic [WIDTH-1:0] START    = 24'h100,
   parameter logic [WIDTH-1:0] LIMIT    = 24'd999900,
   parameter int               PRESCALE = 1
) (
   input logic           clk,
   input logic           rst,
   wrap_counter_if.slave bus
);
   logic [WIDTH-1:0] count, clamped, stepped;
   logic             tc, done, at_end, step;

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("wrap_counter: PRESCALE must be >= 1");
   end
   if (START >= LIMIT) begin : g_bad_range
      $error("wrap_counter: START must be below LIMIT");
   end

   // load clamp and the next value a step would produce, including wrap/hold at the bound
   always_comb begin
      clamped = bus.load_val > LIMIT ? LIMIT : (bus.load_val < START ? START : bus.load_val);
      at_end  = bus.dir ? count == START : count == LIMIT;
      stepped = at_end ? (bus.oneshot ? count : (bus.dir ? LIMIT : START))
                       : (bus.dir ? count - 1'b1 : count + 1'b1);
   end

`ifdef WRAP_COUNTER_PRESCALE_EN
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre;
   logic          hit;
   assign hit  = pre == PW'(PRESCALE - 1);
   assign step = bus.en & ~done & hit;

   // prescaler phase advances on enabled cycles and restarts on clear/load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pre <= '0;
      else if (bus.clear || bus.load) pre <= '0;
      else if (bus.en && !done) pre <= hit ? '0 : pre + 1'b1;
   end
`else
   assign step = bus.en & ~done;
`endif

   // count, terminal pulse and sticky done; clear beats load beats step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= START;
         tc    <= 1'b0;
         done  <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (bus.clear) begin
            count <= bus.dir ? LIMIT : START;
            done  <= 1'b0;
         end else if (bus.load) begin
            count <= clamped;
            done  <= 1'b0;
         end else if (step) begin
            count <= stepped;
            tc    <= at_end;
            done  <= at_end & bus.oneshot;
         end
      end
   end

   assign bus.count = count;
   assign bus.tc    = tc;
   assign bus.done  = done;
endmodule

// File: tb/tb_wrap_counter.sv
// tb_wrap_counter: directed checks of wrap_counter with WIDTH=8, START=10h, LIMIT=14h
module tb_wrap_counter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   wrap_counter_if #(.WIDTH(8)) bus ();

   wrap_counter #(.WIDTH(8), .START(8'h10), .LIMIT(8'h14), .PRESCALE(3)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] up_cnt [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h10, 8'h11};
   logic       up_tc  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [7:0] dn_cnt [4] = '{8'h11, 8'h10, 8'h14, 8'h13};
   logic       dn_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      bus.en = 0; bus.dir = 0; bus.oneshot = 0; bus.clear = 0; bus.load = 0; bus.load_val = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_count", bus.count, 8'h10);
      check("reset_tc", bus.tc, 0);
      check("reset_done", bus.done, 0);

      bus.en = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("up_count%0d", i), bus.count, up_cnt[i]);
         check($sformatf("up_tc%0d", i), bus.tc, up_tc[i]);
      end

      tick();
      bus.en = 0;
      check("pre_async_count", bus.count, 8'h12);
      #2 rst = 1'b1;
      #1;
      check("async_rst_count", bus.count, 8'h10);
      check("async_rst_tc", bus.tc, 0);
      check("async_rst_done", bus.done, 0);
      #1 rst = 1'b0;

      bus.load = 1; bus.load_val = 8'h12;
      tick();
      bus.load = 0;
      check("load12_count", bus.count, 8'h12);
      bus.en = 1; bus.dir = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("dn_count%0d", i), bus.count, dn_cnt[i]);
         check($sformatf("dn_tc%0d", i), bus.tc, dn_tc[i]);
      end

      bus.dir = 0; bus.oneshot = 1;
      tick();
      check("os_count14", bus.count, 8'h14);
      check("os_tc_pre", bus.tc, 0);
      check("os_done_pre", bus.done, 0);
      tick();
      check("os_hold", bus.count, 8'h14);
      check("os_tc", bus.tc, 1);
      check("os_done", bus.done, 1);
      repeat (2) begin
         tick();
         check("os_idle_count", bus.count, 8'h14);
         check("os_idle_tc", bus.tc, 0);
         check("os_idle_done", bus.done, 1);
      end
      bus.en = 0; bus.clear = 1;
      tick();
      bus.clear = 0;
      check("clear_count", bus.count, 8'h10);
      check("clear_done", bus.done, 0);
      check("clear_tc", bus.tc, 0);

      bus.oneshot = 0;
      bus.load = 1; bus.load_val = 8'hFF;
      tick();
      check("load_hi_count", bus.count, 8'h14);
      check("load_hi_tc", bus.tc, 0);
      bus.load_val = 8'h05;
      tick();
      check("load_lo_count", bus.count, 8'h10);
      check("load_lo_tc", bus.tc, 0);
      bus.load_val = 8'h13;
      tick();
      check("load13_count", bus.count, 8'h13);
      bus.clear = 1; bus.load_val = 8'h12;
      tick();
      check("clear_over_load", bus.count, 8'h10);
      check("clear_over_load_tc", bus.tc, 0);
      bus.load = 0; bus.dir = 1;
      tick();
      check("clear_dn_count", bus.count, 8'h14);
      bus.clear = 0; bus.dir = 0;

`ifdef WRAP_COUNTER_PRESCALE_EN
      bus.clear = 1;
      tick();
      bus.clear = 0; bus.en = 1;
      begin
         logic [7:0] ps_cnt [6] = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h11, 8'h12};
         for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("ps_count%0d", i), bus.count, ps_cnt[i]);
         end
      end
      tick();
      check("ps_mid", bus.count, 8'h12);
      bus.load = 1; bus.load_val = 8'h12;
      tick();
      bus.load = 0;
      check("ps_load", bus.count, 8'h12);
      tick();
      check("ps_phase1", bus.count, 8'h12);
      tick();
      check("ps_phase2", bus.count, 8'h12);
      tick();
      check("ps_phase3", bus.count, 8'h13);
      bus.en = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
